// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the framebuffer write port between the pixel drawers
// using round-robin priority, and sweeps the whole screen to index 0 on a
// clear request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ARB   | normal arbitration, at most one pixel write granted per cycle
// ST_CLEAR | full-screen sweep to background index 0; grants suppressed
module draw_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*X_W-1:0]   req_x,
  input  logic [N_REQ*Y_W-1:0]   req_y,
  input  logic [N_REQ*4-1:0]     req_color,
  input  logic                   clear_req,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   fb_we,
  output logic [X_W-1:0]         fb_x,
  output logic [Y_W-1:0]         fb_y,
  output logic [3:0]             fb_color
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [X_W:0]   X_LIM  = (X_W + 1)'(WIDTH);
  localparam logic [Y_W:0]   Y_LIM  = (Y_W + 1)'(HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  logic [0:0]     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           fb_we_q, fb_we_d;
  logic [X_W-1:0] fb_x_q, fb_x_d;
  logic [Y_W-1:0] fb_y_q, fb_y_d;
  logic [3:0]     fb_color_q, fb_color_d;
  logic           clear_done_q, clear_done_d;

  logic [PW-1:0]  win;
  logic           found;
  int             idx_c;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [3:0]     sel_color;

  // Round-robin winner search starting at ptr; grant is suppressed during
  // reset, during a clear, and in the cycle a clear is requested.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx_c = 0;
    if (!reset && state_q == ST_ARB && !clear_req) begin
      for (int o = 0; o < N_REQ; o++) begin
        idx_c = int'(ptr_q) + o;
        if (idx_c >= N_REQ) idx_c = idx_c - N_REQ;
        if (!found && req[idx_c]) begin
          found = 1'b1;
          win   = PW'(idx_c);
        end
      end
      if (found) grant[win] = 1'b1;
    end
  end

  assign sel_x     = req_x[int'(win)*X_W +: X_W];
  assign sel_y     = req_y[int'(win)*Y_W +: Y_W];
  assign sel_color = req_color[int'(win)*4 +: 4];

  // Next-state: load the winner's pixel, or step the clear sweep raster-order.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fb_we_d      = 1'b0;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;
    fb_color_d   = fb_color_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clear_req) begin
          state_d      = ST_CLEAR;
          fb_we_d      = 1'b1;
          fb_x_d       = '0;
          fb_y_d       = '0;
          fb_color_d   = 4'd0;
          clear_done_d = (X_LAST == '0) && (Y_LAST == '0);
        end else if (found) begin
          // Out-of-range pixels are consumed but never written.
          fb_we_d    = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
          fb_x_d     = sel_x;
          fb_y_d     = sel_y;
          fb_color_d = sel_color;
          ptr_d      = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
        end
      end
      default: begin
        // fb_x/fb_y double as the sweep counters.
        if (fb_x_q == X_LAST && fb_y_q == Y_LAST) begin
          state_d = ST_ARB;
        end else begin
          fb_we_d    = 1'b1;
          fb_color_d = 4'd0;
          if (fb_x_q == X_LAST) begin
            fb_x_d = '0;
            fb_y_d = fb_y_q + Y_W'(1);
          end else begin
            fb_x_d = fb_x_q + X_W'(1);
          end
          clear_done_d = (fb_x_d == X_LAST) && (fb_y_d == Y_LAST);
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_ARB;
      ptr_q        <= '0;
      fb_we_q      <= 1'b0;
      fb_x_q       <= '0;
      fb_y_q       <= '0;
      fb_color_q   <= 4'd0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fb_we_q      <= fb_we_d;
      fb_x_q       <= fb_x_d;
      fb_y_q       <= fb_y_d;
      fb_color_q   <= fb_color_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign fb_we      = fb_we_q;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_color   = fb_color_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: a full-size instance (640x480) and a small one
// (4x3) share the pixel requests; only the small one is ever cleared.
module tb_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [9:0]  rx [4];
  logic [8:0]  ry [4];
  logic [3:0]  rc [4];
  logic        clr_b, clr_s;
  logic [39:0] req_x;
  logic [35:0] req_y;
  logic [15:0] req_color;

  logic [3:0]  g_b, g_s;
  logic        busy_b, busy_s, done_b, done_s, we_b, we_s;
  logic [9:0]  x_b, x_s;
  logic [8:0]  y_b, y_s;
  logic [3:0]  c_b, c_s;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit abort_phase = 1'b0;
  int done_cnt = 0;

  assign req_x     = {rx[3], rx[2], rx[1], rx[0]};
  assign req_y     = {ry[3], ry[2], ry[1], ry[0]};
  assign req_color = {rc[3], rc[2], rc[1], rc[0]};

  always #5 clock = ~clock;

  draw_arbiter #(.N_REQ(4), .WIDTH(640), .HEIGHT(480), .X_W(10), .Y_W(9)) dut_big (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .clear_req(clr_b), .grant(g_b), .busy(busy_b),
    .clear_done(done_b), .fb_we(we_b), .fb_x(x_b), .fb_y(y_b), .fb_color(c_b));

  draw_arbiter #(.N_REQ(4), .WIDTH(4), .HEIGHT(3), .X_W(10), .Y_W(9)) dut_small (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .clear_req(clr_s), .grant(g_s), .busy(busy_s),
    .clear_done(done_s), .fb_we(we_s), .fb_x(x_s), .fb_y(y_s), .fb_color(c_s));

  // Model state per instance (0 = big, 1 = small): values the registered
  // outputs hold in the current cycle.
  int m_ptr [2];
  bit m_busy [2];
  int m_idx [2];
  bit m_we [2];
  int m_x [2];
  int m_y [2];
  int m_c [2];
  bit m_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mgrant(input int k, input logic clr);
    if (reset || m_busy[k] || clr) return 4'b0000;
    for (int o = 0; o < 4; o++) begin
      int i;
      i = (m_ptr[k] + o) % 4;
      if (req[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  // Advance model k across the coming rising edge, using current inputs.
  task automatic mstep(input int k, input logic clr);
    int w, h, win;
    logic [3:0] g;
    w = (k == 0) ? 640 : 4;
    h = (k == 0) ? 480 : 3;
    g = mgrant(k, clr);
    if (reset) begin
      m_ptr[k] = 0; m_busy[k] = 0; m_idx[k] = 0; m_we[k] = 0;
      m_x[k] = 0; m_y[k] = 0; m_c[k] = 0; m_done[k] = 0;
    end else if (m_busy[k]) begin
      if (m_idx[k] == w*h - 1) begin
        m_busy[k] = 0; m_we[k] = 0; m_done[k] = 0;
      end else begin
        m_idx[k]++;
        m_x[k] = m_idx[k] % w;
        m_y[k] = m_idx[k] / w;
        m_done[k] = (m_idx[k] == w*h - 1);
      end
    end else begin
      m_done[k] = 0;
      if (clr) begin
        m_busy[k] = 1; m_idx[k] = 0; m_we[k] = 1;
        m_x[k] = 0; m_y[k] = 0; m_c[k] = 0;
        m_done[k] = (w*h == 1);
      end else if (g != 4'b0000) begin
        win = 0;
        for (int i = 0; i < 4; i++) if (g[i]) win = i;
        m_x[k] = int'(rx[win]);
        m_y[k] = int'(ry[win]);
        m_c[k] = int'(rc[win]);
        m_we[k] = (m_x[k] < w) && (m_y[k] < h);
        m_ptr[k] = (win + 1) % 4;
      end else begin
        m_we[k] = 0;
      end
    end
  endtask

  function automatic logic [29:0] mpack(input int k, input logic clr);
    return {mgrant(k, clr), m_we[k], 10'(m_x[k]), 9'(m_y[k]), 4'(m_c[k]),
            m_busy[k], m_done[k]};
  endfunction

  // Compare both instances against the model every cycle, then advance it.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_busy[k] = 0; m_idx[k] = 0; m_we[k] = 0;
      m_x[k] = 0; m_y[k] = 0; m_c[k] = 0; m_done[k] = 0;
    end
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("model_big", 32'({g_b, we_b, x_b, y_b, c_b, busy_b, done_b}),
            32'(mpack(0, clr_b)));
        chk("model_small", 32'({g_s, we_s, x_s, y_s, c_s, busy_s, done_s}),
            32'(mpack(1, clr_s)));
        if (abort_phase && done_s) done_cnt++;
      end
      mstep(0, clr_b);
      mstep(1, clr_s);
    end
  end

  initial begin
    int exp_rr [6];
    exp_rr = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    reset = 1'b1; req = 4'b1111; clr_b = 1'b0; clr_s = 1'b0;
    for (int i = 0; i < 4; i++) begin rx[i] = '0; ry[i] = '0; rc[i] = '0; end

    // Reset with all requests pending.
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1; chk_en = 1'b1; #2;
      chk("rst_grant", 32'(g_b), 32'd0);
      chk("rst_we", 32'(we_b), 32'd0);
      chk("rst_busy", 32'(busy_b), 32'd0);
      chk("rst_done", 32'(done_b), 32'd0);
      chk("rst_xyc", 32'({x_b, y_b, c_b}), 32'd0);
    end

    // Single requester.
    @(posedge clock); #1;
    reset = 1'b0; req = 4'b0100; rx[2] = 10'd100; ry[2] = 9'd50; rc[2] = 4'd3; #2;
    chk("single_grant", 32'(g_b), 32'b0100);
    @(posedge clock); #1; req = 4'b0000; #2;
    chk("single_we", 32'(we_b), 32'd1);
    chk("single_x", 32'(x_b), 32'd100);
    chk("single_y", 32'(y_b), 32'd50);
    chk("single_c", 32'(c_b), 32'd3);

    // Round robin.
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      req = (i < 4) ? 4'b0011 : 4'b1001;
      for (int r = 0; r < 4; r++) begin
        rx[r] = 10'(20 + 4*i + r); ry[r] = 9'(30 + i); rc[r] = 4'(i + r);
      end
      #2;
      chk("rr_grant", 32'(g_b), 32'(exp_rr[i]));
    end

    // Out-of-range then boundary-in-range pixel.
    @(posedge clock); #1;
    req = 4'b0001; rx[0] = 10'd640; ry[0] = 9'd10; rc[0] = 4'd9; #2;
    chk("oor_grant", 32'(g_b), 32'b0001);
    @(posedge clock); #1; rx[0] = 10'd639; ry[0] = 9'd479; #2;
    chk("oor_grant2", 32'(g_b), 32'b0001);
    chk("oor_we", 32'(we_b), 32'd0);
    @(posedge clock); #1; req = 4'b0000; #2;
    chk("edge_we", 32'(we_b), 32'd1);
    chk("edge_xy", 32'({x_b, y_b}), 32'({10'd639, 9'd479}));

    // Clear on the small instance colliding with a request.
    @(posedge clock); #1;
    clr_s = 1'b1; req = 4'b0010; rx[1] = 10'd1; ry[1] = 9'd1; rc[1] = 4'd5; #2;
    chk("clr_nogrant", 32'(g_s), 32'd0);
    chk("clr_big_grant", 32'(g_b), 32'b0010);
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1; clr_s = 1'b0; #2;
      chk("clr_we", 32'(we_s), 32'd1);
      chk("clr_xy", 32'({x_s, y_s}), 32'({10'(k % 4), 9'(k / 4)}));
      chk("clr_c", 32'(c_s), 32'd0);
      chk("clr_busy", 32'(busy_s), 32'd1);
      chk("clr_done", 32'(done_s), 32'(k == 11));
      chk("clr_grant", 32'(g_s), 32'd0);
    end
    @(posedge clock); #1; #2;
    chk("post_busy", 32'(busy_s), 32'd0);
    chk("post_grant", 32'(g_s), 32'b0010);
    @(posedge clock); #1; req = 4'b0000; #2;
    chk("post_we", 32'(we_s), 32'd1);
    chk("post_xy", 32'({x_s, y_s, c_s}), 32'({10'd1, 9'd1, 4'd5}));

    // Reset at the 5th clear write.
    @(posedge clock); #1; clr_s = 1'b1; abort_phase = 1'b1; #2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1; clr_s = 1'b0;
      if (k == 4) reset = 1'b1;
      #2;
      chk("abort_xy", 32'({x_s, y_s}), 32'({10'(k % 4), 9'(k / 4)}));
    end
    @(posedge clock); #1;
    reset = 1'b0; req = 4'b1000; rx[3] = 10'd2; ry[3] = 9'd1; rc[3] = 4'd7; #2;
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_we", 32'(we_s), 32'd0);
    chk("abort_grant", 32'(g_s), 32'b1000);
    @(posedge clock); #1; req = 4'b0000; #2;
    chk("abort_next_we", 32'(we_s), 32'd1);
    chk("abort_next_x", 32'(x_s), 32'd2);
    repeat (4) @(posedge clock);
    #3;
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
